// File: rtl/display_scan_7seg.sv
// Six-digit common-anode 7-segment scanner with config-digit blinking.
// Optional: LEADING_ZERO_BLANK_EN blanks a zero hours-tens digit outside config mode.
module display_scan_7seg #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] s_unidade,
    input  logic [3:0] s_dezena,
    input  logic [3:0] m_unidade,
    input  logic [3:0] m_dezena,
    input  logic [3:0] h_unidade,
    input  logic [3:0] h_dezena,
    input  logic [2:0] config_digit,
    input  logic       is_config,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an
);

    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [2:0]    idx;
    logic [SW-1:0] scan_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink_ph;
    logic          prev_cfg;
    logic [2:0]    prev_digit;

    logic [3:0] digit;
    logic [6:0] seg_dec;
    logic [6:0] seg_nxt;
    logic [5:0] an_nxt;
    logic       dp_nxt;
    logic       blank;
    logic       restart;

    always_comb begin
        digit = 4'hF;
        case (idx)
            3'd0:    digit = s_unidade;
            3'd1:    digit = s_dezena;
            3'd2:    digit = m_unidade;
            3'd3:    digit = m_dezena;
            3'd4:    digit = h_unidade;
            3'd5:    digit = h_dezena;
            default: digit = 4'hF;
        endcase
    end

    always_comb begin
        seg_dec = 7'b1111111;
        case (digit)
            4'd0:    seg_dec = 7'b1000000;
            4'd1:    seg_dec = 7'b1111001;
            4'd2:    seg_dec = 7'b0100100;
            4'd3:    seg_dec = 7'b0110000;
            4'd4:    seg_dec = 7'b0011001;
            4'd5:    seg_dec = 7'b0010010;
            4'd6:    seg_dec = 7'b0000010;
            4'd7:    seg_dec = 7'b1111000;
            4'd8:    seg_dec = 7'b0000000;
            4'd9:    seg_dec = 7'b0010000;
            default: seg_dec = 7'b1111111;
        endcase
    end

    always_comb begin
        // idx never reaches 6/7, so those config_digit values never blank
        blank = is_config && (idx == config_digit) && blink_ph;
`ifdef LEADING_ZERO_BLANK_EN
        if (!is_config && (idx == 3'd5) && (h_dezena == 4'd0))
            blank = 1'b1;
`endif
        seg_nxt = blank ? 7'b1111111 : seg_dec;
        an_nxt  = ~(6'd1 << idx);
        dp_nxt  = !((idx == 3'd2) || (idx == 3'd4));
        restart = is_config && (!prev_cfg || (config_digit != prev_digit));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx        <= 3'd0;
            scan_cnt   <= '0;
            blink_cnt  <= '0;
            blink_ph   <= 1'b0;
            prev_cfg   <= 1'b0;
            prev_digit <= 3'd0;
            an         <= 6'b111111;
            seg        <= 7'b1111111;
            dp         <= 1'b1;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            // restart wins over a coincident toggle
            if (!is_config || restart) begin
                blink_cnt <= '0;
                blink_ph  <= 1'b0;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
            prev_cfg   <= is_config;
            prev_digit <= config_digit;
        end
    end

endmodule

// File: tb/tb_display_scan_7seg.sv
// Randomized bench for display_scan_7seg against a cycle-count model.
// Honours LEADING_ZERO_BLANK_EN when defined.
module tb_display_scan_7seg;

    localparam int SD = 4;
    localparam int BD = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] s_unidade, s_dezena, m_unidade, m_dezena, h_unidade, h_dezena;
    logic [2:0] config_digit;
    logic       is_config;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;

    display_scan_7seg #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk(clk), .reset(reset),
        .s_unidade(s_unidade), .s_dezena(s_dezena),
        .m_unidade(m_unidade), .m_dezena(m_dezena),
        .h_unidade(h_unidade), .h_dezena(h_dezena),
        .config_digit(config_digit), .is_config(is_config),
        .seg(seg), .dp(dp), .an(an)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int errs = 0;

    logic [6:0] dec [16];
    initial begin
        dec[0] = 7'b1000000; dec[1] = 7'b1111001; dec[2] = 7'b0100100;
        dec[3] = 7'b0110000; dec[4] = 7'b0011001; dec[5] = 7'b0010010;
        dec[6] = 7'b0000010; dec[7] = 7'b1111000; dec[8] = 7'b0000000;
        dec[9] = 7'b0010000;
        for (int i = 10; i < 16; i++) dec[i] = 7'b1111111;
    end

    // Model: k = edges since reset, age = edges since last blink restart
    int k = 0;
    int age = 0;
    logic pcfg = 1'b0;
    logic [2:0] pcd = 3'd0;
    logic [5:0] e_an = 6'h3F;
    logic [6:0] e_seg = 7'h7F;
    logic e_dp = 1'b1;

    always @(posedge clk) begin
        if (!reset) begin
            k = 0; age = 0; pcfg = 1'b0; pcd = 3'd0;
            e_an = 6'h3F; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
            int mi;
            logic [3:0] d [6];
            logic bl;
            logic rs;
            mi = (k / SD) % 6;
            d[0] = s_unidade; d[1] = s_dezena; d[2] = m_unidade;
            d[3] = m_dezena;  d[4] = h_unidade; d[5] = h_dezena;
            bl = is_config && (mi == int'(config_digit)) && (((age / BD) % 2) == 1);
`ifdef LEADING_ZERO_BLANK_EN
            if (!is_config && mi == 5 && h_dezena == 4'd0) bl = 1'b1;
`endif
            e_seg = bl ? 7'h7F : dec[d[mi]];
            e_an = ~(6'd1 << mi);
            e_dp = !(mi == 2 || mi == 4);
            rs = is_config && (!pcfg || config_digit != pcd);
            k++;
            if (!is_config || rs) age = 0;
            else age++;
            pcfg = is_config;
            pcd = config_digit;
        end
    end

    always @(negedge clk) begin
        logic [5:0] xa;
        logic [6:0] xs;
        logic xd;
        xa = reset ? e_an : 6'h3F;
        xs = reset ? e_seg : 7'h7F;
        xd = reset ? e_dp : 1'b1;
        vec++;
        if (an !== xa || seg !== xs || dp !== xd) begin
            errs++;
            $display("FAIL model k=%0d an=%b/%b seg=%b/%b dp=%b/%b (got/exp)",
                     k, an, xa, seg, xs, dp, xd);
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s got=%b exp=%b", nm, act, exp);
        end
    endtask

    task automatic set_digits(input logic [3:0] hd, hu, md, mu, sd, su);
        h_dezena = hd; h_unidade = hu; m_dezena = md;
        m_unidade = mu; s_dezena = sd; s_unidade = su;
    endtask

    logic [5:0] an_seq [7];
    logic [6:0] pat [6];
    initial begin
        an_seq[0] = 6'b111110; an_seq[1] = 6'b111101; an_seq[2] = 6'b111011;
        an_seq[3] = 6'b110111; an_seq[4] = 6'b101111; an_seq[5] = 6'b011111;
        an_seq[6] = 6'b111110;
        pat[0] = 7'b0000010; pat[1] = 7'b0010010; pat[2] = 7'b0011001;
        pat[3] = 7'b0110000; pat[4] = 7'b0100100; pat[5] = 7'b1111001;
    end

    initial begin
        int li;
        int guard;
        reset = 1'b0;
        is_config = 1'b0;
        config_digit = 3'd0;
        set_digits(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_an", {2'b0, an}, 8'h3F);
        chk("rst_seg", {1'b0, seg}, 8'h7F);
        chk("rst_dp", {7'b0, dp}, 8'h01);
        reset = 1'b1;

        for (int j = 0; j < 7; j++) begin
            repeat (j == 0 ? 1 : SD) @(negedge clk);
            chk("scan_an", {2'b0, an}, {2'b0, an_seq[j]});
            chk("scan_seg0", {1'b0, seg}, 8'b01000000);
        end

        set_digits(1, 2, 3, 4, 5, 6);
        for (int j = 0; j < 24; j++) begin
            @(negedge clk);
            li = ((k - 1) / SD) % 6;
            chk("pat_seg", {1'b0, seg}, {1'b0, pat[li]});
            chk("pat_dp", {7'b0, dp}, (li == 2 || li == 4) ? 8'd0 : 8'd1);
        end

        s_unidade = 4'hC;
        for (int j = 0; j < 24; j++) begin
            @(negedge clk);
            li = ((k - 1) / SD) % 6;
            if (li == 0) chk("code_c", {1'b0, seg}, 8'h7F);
            if (li == 1) chk("code_c_nb", {1'b0, seg}, 8'b00010010);
        end
        s_unidade = 4'd6;

        config_digit = 3'd2;
        is_config = 1'b1;
        repeat (12) @(negedge clk);
        config_digit = 3'd3;
        repeat (60) @(negedge clk);
        config_digit = 3'd6;
        repeat (30) @(negedge clk);
        is_config = 1'b0;
        repeat (10) @(negedge clk);

        for (int j = 0; j < 3000; j++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0)
                set_digits($urandom_range(0, 15), $urandom_range(0, 15),
                           $urandom_range(0, 15), $urandom_range(0, 15),
                           $urandom_range(0, 15), $urandom_range(0, 15));
            if ($urandom_range(0, 63) == 0) is_config = ~is_config;
            if ($urandom_range(0, 31) == 0) config_digit = 3'($urandom_range(0, 7));
        end

        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (((k / SD) % 6) != 3 && guard < 40);
        chk("reach_idx3", {7'b0, guard < 40}, 8'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_an", {2'b0, an}, 8'h3F);
        chk("async_seg", {1'b0, seg}, 8'h7F);
        chk("async_dp", {7'b0, dp}, 8'h01);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("resume_an", {2'b0, an}, 8'b00111110);
        repeat (30) @(negedge clk);

        is_config = 1'b0;
        set_digits(0, 1, 2, 3, 4, 5);
        repeat (30) @(negedge clk);
        is_config = 1'b1;
        config_digit = 3'd0;
        repeat (30) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/display_scan_7seg.md
Name: display_scan_7seg

Overview:
- Consumer end of the watch FSM display interface.
- Takes the six BCD digit outputs plus config_digit/is_config from the mode FSM.
- Time-multiplexes the digits onto one common-anode 7-segment bus with six anode strobes.
- Blinks the digit under configuration so the user can see which position is being edited.

Parameters:
- SCAN_DIV, 50000: clocks each digit stays selected; minimum 2.
- BLINK_DIV, 12500000: clocks per blink half-period, visible or blank; minimum 2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- s_unidade  in  4  seconds units, BCD
- s_dezena  in  4  seconds tens, BCD
- m_unidade  in  4  minutes units, BCD
- m_dezena  in  4  minutes tens, BCD
- h_unidade  in  4  hours units, BCD
- h_dezena  in  4  hours tens, BCD
- config_digit  in  3  position being edited, 0..5
- is_config  in  1  FSM is in configuration mode
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- an  out  6  digit anodes, active-low, one-hot; bit i = digit index i

Behaviour:
- Reset is asynchronous, active-low, on reset; clock is clk.
- Reset values:
  - an = 6'b111111, seg = 7'b1111111, dp = 1.
  - Internal: idx = 0, scan_cnt = 0, blink_cnt = 0, blink_ph = 0 (visible), prev_cfg = 0, prev_digit = 0.
- Digit index map: 0 s_unidade, 1 s_dezena, 2 m_unidade, 3 m_dezena, 4 h_unidade, 5 h_dezena.
- Scan counter:
  - scan_cnt increments every clk.
  - At SCAN_DIV-1 it wraps to 0 and idx advances 0→1→…→5→0.
- Outputs are registered and reflect idx one cycle after it changes.
  - an = ~(1<<idx).
  - seg = decode of the selected digit, sampled live (no frame snapshot).
- Decode, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Codes 10..15 display blank (1111111).
- dp = 0 (lit) on idx 2 and 4 as hh.mm.ss separators; 1 elsewhere.
  - In config mode dp stays lit on those indices, independent of blink.
- Blink counter:
  - Runs only while is_config = 1; it is held at blink_cnt = 0, blink_ph = 0 otherwise.
  - At BLINK_DIV-1 it wraps and blink_ph toggles.
- Blank condition: is_config = 1, idx == config_digit, and blink_ph = 1 → seg = 1111111.
  - an is still strobed during the blank.
  - dp follows the normal rule.
- Restart: a rising edge of is_config, or any change of config_digit while is_config = 1, clears blink_cnt and blink_ph the next cycle.
  - The newly selected digit is therefore shown visible immediately.
- config_digit values 6 or 7: no digit blanks; scanning is unaffected.
- Simultaneous events:
  - The scan wrap and the blink wrap are independent.
  - A blink restart takes priority over a blink toggle in the same cycle.
- Reset mid-scan: outputs go to their reset values immediately (asynchronous); scanning restarts at idx 0.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined:
  - When is_config = 0 and h_dezena == 0, idx 5 shows blank seg.
  - In config mode this blanking is disabled so the user can edit h_dezena.
- Undefined: h_dezena = 0 displays "0" normally.

Test Plan:
- SCAN_DIV=4. Reset asserted then released, all digits = 0 → an steps 111110, 111101, 111011, 110111, 101111, 011111, 111110 every 4 clks; seg = 1000000 throughout.
- Digits h=1,2 m=3,4 s=5,6, i.e. h_dezena=1, h_unidade=2, m_dezena=3, m_unidade=4, s_dezena=5, s_unidade=6 → per idx:
  - seg: idx0 0000010, idx1 0010010, idx2 0011001, idx3 0110000, idx4 0100100, idx5 1111001.
  - dp = 0 only at idx 2 and 4.
- s_unidade = 4'hC → idx 0 shows seg = 1111111; all other digits unaffected.
- BLINK_DIV=8, is_config=1, config_digit=2:
  - idx 2 shows its digit for the first 8 clks after is_config rises, then blanks for 8 clks, alternating.
  - Other indices are never blanked.
- During a blank phase, config_digit changes 2→3 → the next cycle blink_ph = 0; idx 3 is visible for a full 8 clks, then blanks.
- reset pulsed low mid-scan at idx 3 → an = 111111, seg = 1111111 asynchronously; after release scanning resumes at idx 0.
- With LEADING_ZERO_BLANK_EN, h_dezena=0, is_config=0 → idx 5 blank; is_config=1 → idx 5 shows 1000000.
